bist_tpg: RTL

BIST_TPG -- requirements
Module: bist_tpg

---
 rtl/bist_pkg.sv | 21 ++
 rtl/lfsr16.sv | 30 +++
 rtl/bist_tpg.sv | 116 +++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the built-in self-test pattern generator:
// FSM state encoding, pattern width and the LFSR tap mask.
package bist_pkg;

  localparam int TPG_W = 16;

  // Taps for x^16+x^14+x^13+x^11+1 seen from the MSB: bits 15, 13, 12, 10
  localparam logic [TPG_W-1:0] TPG_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One Fibonacci step: shift left, feedback is the parity of the tapped bits
  function automatic logic [TPG_W-1:0] lfsr_next(input logic [TPG_W-1:0] q);
    return {q[TPG_W-2:0], ^(q & TPG_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and advance-enable.
// A zero seed is replaced by 16'h0001 so the register never locks up at zero;
// reset also leaves a non-zero value in the register.
module lfsr16
  import bist_pkg::*;
(
  input  logic             CK,
  input  logic             RST,
  input  logic             load,
  input  logic [TPG_W-1:0] seed,
  input  logic             adv,
  output logic [TPG_W-1:0] q
);

  logic [TPG_W-1:0] q_r;

  // Load has priority over advance; the zero seed is mapped to one
  always_ff @(posedge CK) begin
    if (RST) begin
      q_r <= 16'h0001;
    end else if (load) begin
      q_r <= (seed == '0) ? 16'h0001 : seed;
    end else if (adv) begin
      q_r <= lfsr_next(q_r);
    end
  end

  assign q = q_r;

endmodule

// File: rtl/bist_tpg.sv
// BIST test pattern generator: emits N_PAT LFSR patterns per run over a
// valid/ready port, then pulses done and returns to IDLE.
// Handshake: pat_valid is high for the whole of RUN and does not depend on
// pat_ready; a pattern is consumed on any rising CK edge where
// pat_valid & pat_ready, and pat/pat_idx hold stable until then.
// Optional feature: define BIST_TPG_ALLZERO_EN to emit 16'h0000 as pattern
// index 0, followed by the seed and the rest of the LFSR sequence.
module bist_tpg
  import bist_pkg::*;
#(
  parameter int               N_PAT = 1024,
  parameter logic [TPG_W-1:0] SEED  = 16'hACE1
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic             pat_ready,
  output logic [TPG_W-1:0] pat,
  output logic             pat_valid,
  output logic             busy,
  output logic             done,
  output logic [TPG_W-1:0] pat_idx
);

  localparam logic [TPG_W-1:0] LAST_IDX = TPG_W'(N_PAT - 1);

  state_e           state_q, state_d;
  logic [TPG_W-1:0] idx_q;
  logic [TPG_W-1:0] lfsr_q;
  logic             shown_q;   // a run has loaded the LFSR since reset
  logic             zphase;    // currently presenting the all-zero pattern
  logic             start_run;
  logic             hs;
  logic             last;

  assign start_run = (state_q == IDLE) && start;
  assign hs        = (state_q == RUN) && pat_ready;
  assign last      = (idx_q == LAST_IDX);

  lfsr16 u_lfsr (
    .CK   (CK),
    .RST  (RST),
    .load (start_run),
    .seed (SEED),
    .adv  (hs && !last && !zphase),
    .q    (lfsr_q)
  );

`ifdef BIST_TPG_ALLZERO_EN
  logic zphase_q;

  // Zero pattern occupies index 0; the first handshake reveals the seed
  always_ff @(posedge CK) begin
    if (RST) begin
      zphase_q <= 1'b0;
    end else if (start_run) begin
      zphase_q <= 1'b1;
    end else if (hs && !last) begin
      zphase_q <= 1'b0;
    end
  end

  assign zphase = zphase_q;
`else
  assign zphase = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pattern index and the flag that un-masks the LFSR onto pat
  always_ff @(posedge CK) begin
    if (RST) begin
      idx_q   <= '0;
      shown_q <= 1'b0;
    end else if (start_run) begin
      idx_q   <= '0;
      shown_q <= 1'b1;
    end else if (hs && !last) begin
      idx_q   <= idx_q + 1'b1;
    end
  end

  // Next-state and Moore outputs
  always_comb begin
    state_d   = state_q;
    pat_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        pat_valid = 1'b1;
        busy      = 1'b1;
        if (pat_ready && last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pat     = (shown_q && !zphase) ? lfsr_q : '0;
  assign pat_idx = idx_q;

endmodule
